mem_param_sync: RTL and testbench

//  Parametrised single-port synchronous memory; next generation of the team's 8x32 training memory.

---
 rtl/mem_param_pkg.sv | 13 +
 rtl/mem_init_seq.sv | 48 ++++
 rtl/mem_param_sync.sv | 133 +++++++++++++
 tb/tb_mem_param_sync.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_param_pkg.sv
// Shared types and constants for the parametrised single-port memory.
// Imported by the init sequencer and the memory top.
package mem_param_pkg;

    typedef enum logic {INIT, RUN} mem_state_t;

    localparam int ERR_CNT_W = 8;

    function automatic bit dwidth_ok(input int w);
        return (w > 0) && ((w % 8) == 0);
    endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset init sequencer: walks every address once, then hands the memory to the user port.
module mem_init_seq
    import mem_param_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              init_we,
    output logic [AWIDTH-1:0] init_addr
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    mem_state_t        state_q, state_d;
    logic [AWIDTH-1:0] init_ptr_q, init_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Leave INIT on the edge that writes the last word, so busy drops together with that write.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == INIT) begin
            if (init_ptr_q == LAST_ADDR) begin
                state_d    = RUN;
                init_ptr_d = '0;
            end else begin
                init_ptr_d = init_ptr_q + 1'b1;
            end
        end
    end

    assign busy      = (state_q == INIT);
    assign init_we   = (state_q == INIT) && !rst;
    assign init_addr = init_ptr_q;

endmodule

// File: rtl/mem_param_sync.sv
// Parametrised single-port synchronous memory with byte enables, registered read,
// hardware init after reset and protocol-error flagging with a saturating counter.
module mem_param_sync
    import mem_param_pkg::*;
#(
    parameter int                DWIDTH   = 8,
    parameter int                DEPTH    = 32,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0,
    localparam int               AWIDTH   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AWIDTH-1:0]    addr,
    input  logic [DWIDTH-1:0]    data_in,
    input  logic [DWIDTH/8-1:0]  be,
    input  logic                 write,
    input  logic                 read,
    output logic [DWIDTH-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                   NBYTES  = DWIDTH / 8;
    localparam logic [AWIDTH:0]      DEPTH_W = (AWIDTH + 1)'(DEPTH);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    if (!dwidth_ok(DWIDTH) || (DEPTH < 2)) begin : g_bad_param
        $error("mem_param_sync: DWIDTH must be a multiple of 8 and DEPTH must be at least 2");
    end

    logic                 init_we;
    logic [AWIDTH-1:0]    init_addr;

    logic                 in_range;
    logic                 user_wr;
    logic                 user_rd;
    logic                 reject;

    logic                 mem_we;
    logic [AWIDTH-1:0]    mem_addr;
    logic [DWIDTH-1:0]    mem_wdata;
    logic [NBYTES-1:0]    mem_be;

    logic [DWIDTH-1:0]    mem [DEPTH];

    logic [DWIDTH-1:0]    data_out_q, data_out_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    mem_init_seq #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr)
    );

    // A request is serviced only in RUN with exactly one of read/write and an address inside the array.
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_W);
        user_wr  = !rst && !busy && write && !read && in_range;
        user_rd  = !rst && !busy && read && !write && in_range;
        reject   = !rst && (read || write) && (busy || (read && write) || !in_range);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr;
        mem_wdata = data_in;
        mem_be    = be;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_addr  = init_addr;
            mem_wdata = INIT_VAL;
            mem_be    = '1;
        end else if (user_wr) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (user_rd) begin
            data_out_d = mem[addr];
            rd_valid_d = 1'b1;
        end
        if (reject) begin
            err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mem_param_sync.sv
// Scoreboard bench for mem_param_sync: stimulus pushes expected responses from a
// behavioural memory model, a negedge monitor pops and compares them.
module tb_mem_param_sync;

    localparam int          DW    = 16;
    localparam int          DEP   = 20;
    localparam int          AW    = $clog2(DEP);
    localparam logic [15:0] IVAL  = 16'hA5A5;

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [15:0] dout;
        logic [7:0]  ecnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    be = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          busy;
    logic          err;
    logic [7:0]    err_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];

    // Reference model state
    logic [15:0] m_mem [DEP];
    int          m_init_left = 0;
    int          m_errc = 0;
    logic [15:0] m_dout = '0;

    mem_param_sync #(
        .DWIDTH   (DW),
        .DEPTH    (DEP),
        .INIT_VAL (IVAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .be       (be),
        .write    (write),
        .read     (read),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Drives one edge's worth of inputs and advances the model by that edge.
    task automatic applyStimulus(input bit r, input bit w, input bit rd,
                                 input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; write = w; read = rd; addr = a; data_in = d; be = b;
        e.cyc = cyc + 1;
        e.is_err = 1'b0;
        if (r) begin
            m_init_left = DEP;
            m_errc = 0;
            m_dout = '0;
            for (int i = 0; i < DEP; i++) m_mem[i] = IVAL;
        end else if (m_init_left > 0) begin
            if (w || rd) begin
                if (m_errc < 255) m_errc++;
                e.is_err = 1'b1; e.dout = m_dout; e.ecnt = 8'(m_errc);
                sb.push_back(e);
            end
            m_init_left--;
        end else if ((w || rd) && ((w && rd) || int'(a) >= DEP)) begin
            if (m_errc < 255) m_errc++;
            e.is_err = 1'b1; e.dout = m_dout; e.ecnt = 8'(m_errc);
            sb.push_back(e);
        end else if (w) begin
            for (int i = 0; i < 2; i++) if (b[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end else if (rd) begin
            m_dout = m_mem[a];
            e.dout = m_dout; e.ecnt = 8'(m_errc);
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Called at the negedge before the first post-reset edge; counts edges that see busy high.
    task automatic countBusy(input bit do_write, output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1) break;
            cnt++;
            applyStimulus(1'b0, do_write, 1'b0, AW'($urandom_range(0, DEP-1)), 16'($urandom), 2'b11);
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_err) begin
                    checkOutput("err_pulse", 32'(err), 32'd1);
                    checkOutput("err_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    checkOutput("rd_valid", 32'(rd_valid), 32'd1);
                    checkOutput("rd_no_err", 32'(err), 32'd0);
                end
                checkOutput("data_out", 32'(data_out), 32'(e.dout));
                checkOutput("err_cnt", 32'(err_cnt), 32'(e.ecnt));
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("missed_response", 32'(e.cyc), 32'(cyc));
            end else if (rd_valid !== 1'b0 || err !== 1'b0) begin
                checkOutput("unexpected_pulse", {30'd0, rd_valid, err}, 32'd0);
            end
        end
    end

    initial begin
        int cnt;
        int kind;

        // Reset and init length
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle();
        @(negedge clk);
        mon_en = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd1);
        checkOutput("reset_data_out", 32'(data_out), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        countBusy(1'b0, cnt);
        checkOutput("busy_edges", 32'(cnt), 32'(DEP));
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(0), '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(19), '0, '0);

        // Byte enables
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(3), 16'h1234, 2'b01);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(3), '0, '0);
        idle();

        // Protocol errors
        applyStimulus(1'b0, 1'b1, 1'b1, AW'(5), 16'hFFFF, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(5), '0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(20), '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(31), 16'h5555, 2'b11);

        // Back-to-back write then read, plus a be=0 no-op write
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(7), 16'hBEEF, 2'b11);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(7), '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(7), 16'h0000, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b1, AW'(7), '0, '0);
        idle();
        @(negedge clk);
        checkOutput("be0_hold_data_out", 32'(data_out), 32'hBEEF);

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            applyStimulus(1'b0, kind inside {[1:4], 9}, kind inside {[5:9]},
                          AW'($urandom_range(0, 23)), 16'($urandom), 2'($urandom));
        end
        idle();

        // Reset in the middle of init, with writes issued during INIT
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (10) idle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, AW'(2), 16'h1111, 2'b11);
        @(negedge clk);
        checkOutput("midinit_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("midinit_busy", 32'(busy), 32'd1);
        countBusy(1'b1, cnt);
        checkOutput("midinit_busy_edges", 32'(cnt), 32'(DEP));
        for (int i = 0; i < DEP; i++) applyStimulus(1'b0, 1'b0, 1'b1, AW'(i), '0, '0);
        idle();

        // Saturation of the error counter
        repeat (300) applyStimulus(1'b0, 1'b0, 1'b1, AW'(25), '0, '0);
        idle();
        @(negedge clk);
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle();
        @(negedge clk);
        checkOutput("rst_clears_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_clears_data_out", 32'(data_out), 32'd0);

        repeat (3) idle();
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
